ir_bus_regs: RTL and testbench

- Bus-slave register stage directly upstream of the IR transmitter wrapper.
- Decodes processor bus writes and reads in the IR address window (base 0x90).
- Holds the car COMMAND and COLOUR_SEL values that drive the transmitter.
- A watchdog auto-clears COMMAND if the processor stops refreshing it, so the car stops when the software stalls.

---
 rtl/ir_bus_regs_pkg.sv | 38 +++
 rtl/ir_tick_gen.sv | 31 +++
 rtl/ir_bus_regs.sv | 152 +++++++++++++++
 tb/tb_ir_bus_regs.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_bus_regs_pkg.sv
// Shared definitions for the IR bus register block and the transmitter mux.
package ir_bus_regs_pkg;

  // Register offsets inside the four-address IR window.
  localparam logic [1:0] REG_CMD     = 2'd0;
  localparam logic [1:0] REG_COLOUR  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  // STATUS register bit positions.
  localparam int STAT_ACTIVE  = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_ERR     = 2;

  // COMMAND bit positions: {fwd, back, left, right}.
  localparam int CMD_RIGHT = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_BACK  = 2;
  localparam int CMD_FWD   = 3;

  // One-hot car select codes: {yellow, green, blue, red}.
  localparam logic [3:0] COLOUR_RED    = 4'b0001;
  localparam logic [3:0] COLOUR_BLUE   = 4'b0010;
  localparam logic [3:0] COLOUR_GREEN  = 4'b0100;
  localparam logic [3:0] COLOUR_YELLOW = 4'b1000;

  // Command state: IDLE means the car is stopped.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // True when exactly one bit of a 4-bit value is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running prescaler emitting a one-cycle TICK every CLK_FREQ_HZ/TICK_HZ cycles.
module ir_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int DIV   = (CLK_FREQ_HZ / TICK_HZ > 0) ? CLK_FREQ_HZ / TICK_HZ : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign TICK = (cnt_q == LAST);

  // Count 0..DIV-1 and wrap; bus activity never touches this counter.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (RST) begin
      cnt_q <= '0;
    end else if (TICK) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ir_bus_regs.sv
// Bus-slave register stage feeding the IR transmitter, with a command watchdog.
module ir_bus_regs
  import ir_bus_regs_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR       = 8'h90,
  parameter int         CLK_FREQ_HZ     = 50_000_000,
  parameter int         TICK_HZ         = 100,
  parameter logic [7:0] DEFAULT_TIMEOUT = 8'd50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  input  logic       BUS_RE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic [3:0] COMMAND,
  output logic [3:0] COLOUR_SEL,
  output logic       CMD_ACTIVE
);

  state_e     state_q, state_d;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] colour_q;
  logic [7:0] timeout_q;
  logic       flag_timeout_q, flag_err_q;
  logic       expire;
  logic       tick;

  logic [7:0] offset;
  logic       in_win, wr_en, rd_en, cmd_wr, status_rd;
  logic [1:0] reg_sel;
  logic [7:0] rd_data;

  ir_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ)
  ) u_tick_gen (
    .CLK (CLK),
    .RST (RST),
    .TICK(tick)
  );

  // Address decode; a simultaneous write suppresses the read.
  always_comb begin
    offset    = BUS_ADDR - BASE_ADDR;
    in_win    = (offset < 8'd4);
    reg_sel   = offset[1:0];
    wr_en     = BUS_WE && in_win;
    rd_en     = BUS_RE && !BUS_WE && in_win;
    cmd_wr    = wr_en && (reg_sel == REG_CMD);
    status_rd = rd_en && (reg_sel == REG_STATUS);
  end

  // Next-state logic: CMD writes win over watchdog expiry on the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d = state_q;
    cmd_d   = cmd_q;
    timer_d = timer_q;
    expire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_wr && (BUS_DATA_IN[3:0] != 4'd0)) begin
          state_d = ST_ACTIVE;
          cmd_d   = BUS_DATA_IN[3:0];
          timer_d = timeout_q;
        end
      end
      ST_ACTIVE: begin
        if (cmd_wr) begin
          cmd_d   = BUS_DATA_IN[3:0];
          timer_d = timeout_q;
          if (BUS_DATA_IN[3:0] == 4'd0) state_d = ST_IDLE;
        end else if (tick && (timeout_q != 8'd0)) begin
          if (timer_q <= 8'd1) begin
            expire  = 1'b1;
            state_d = ST_IDLE;
            cmd_d   = 4'd0;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command state, live command and watchdog timer registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'd0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      timer_q <= timer_d;
    end
  end

  // Configuration registers and sticky flags; a flag set beats a read-clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      colour_q       <= COLOUR_RED;
      timeout_q      <= DEFAULT_TIMEOUT;
      flag_timeout_q <= 1'b0;
      flag_err_q     <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == REG_TIMEOUT)) timeout_q <= BUS_DATA_IN;
      if (expire)         flag_timeout_q <= 1'b1;
      else if (status_rd) flag_timeout_q <= 1'b0;
      if (wr_en && (reg_sel == REG_COLOUR)) begin
        if (is_onehot4(BUS_DATA_IN[3:0])) colour_q   <= BUS_DATA_IN[3:0];
        else                              flag_err_q <= 1'b1;
      end else if (status_rd) begin
        flag_err_q <= 1'b0;
      end
    end
  end

  // Read data mux from the pre-edge register contents.
  always_comb begin
    rd_data = 8'h00;
    unique case (reg_sel)
      REG_CMD:     rd_data = {4'd0, cmd_q};
      REG_COLOUR:  rd_data = {4'd0, colour_q};
      REG_STATUS:  rd_data = {5'd0, flag_err_q, flag_timeout_q, (state_q == ST_ACTIVE)};
      REG_TIMEOUT: rd_data = timeout_q;
      default:     rd_data = 8'h00;
    endcase
  end

  // Registered read port: data and OE are valid for one cycle after the strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BUS_DATA_OUT <= 8'h00;
      BUS_DATA_OE  <= 1'b0;
    end else begin
      BUS_DATA_OE  <= rd_en;
      BUS_DATA_OUT <= rd_en ? rd_data : 8'h00;
    end
  end

  assign COMMAND    = cmd_q;
  assign COLOUR_SEL = colour_q;
  assign CMD_ACTIVE = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ir_bus_regs.sv
// Self-checking bench for ir_bus_regs with a register-level reference model.
module tb_ir_bus_regs;

  localparam int         CLK_HZ  = 100;
  localparam int         TICK_HZ = 10;
  localparam int         DIV     = CLK_HZ / TICK_HZ;
  localparam logic [7:0] BASE    = 8'h90;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] BUS_ADDR, BUS_DATA_IN, BUS_DATA_OUT;
  logic       BUS_WE, BUS_RE, BUS_DATA_OE, CMD_ACTIVE;
  logic [3:0] COMMAND, COLOUR_SEL;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the architectural registers as the bus sees them.
  int         m_cyc;
  logic [3:0] m_cmd, m_colour;
  logic [7:0] m_tmo, m_timer;
  logic       m_tflag, m_err;
  logic       exp_oe;
  logic [7:0] exp_dout;

  ir_bus_regs #(
    .BASE_ADDR      (BASE),
    .CLK_FREQ_HZ    (CLK_HZ),
    .TICK_HZ        (TICK_HZ),
    .DEFAULT_TIMEOUT(8'd50)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_DATA_IN (BUS_DATA_IN),
    .BUS_WE      (BUS_WE),
    .BUS_RE      (BUS_RE),
    .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_DATA_OE (BUS_DATA_OE),
    .COMMAND     (COMMAND),
    .COLOUR_SEL  (COLOUR_SEL),
    .CMD_ACTIVE  (CMD_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_cyc    = 0;
    m_cmd    = 4'd0;
    m_colour = 4'b0001;
    m_tmo    = 8'd50;
    m_timer  = 8'd0;
    m_tflag  = 1'b0;
    m_err    = 1'b0;
    exp_oe   = 1'b0;
    exp_dout = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return {4'd0, m_cmd};
      2'd1:    return {4'd0, m_colour};
      2'd2:    return {5'd0, m_err, m_tflag, (m_cmd != 4'd0)};
      default: return m_tmo;
    endcase
  endfunction

  // One clock edge of the register map's rules, given the bus inputs of that cycle.
  task automatic model_step(input logic we, input logic re, input logic [7:0] addr,
                            input logic [7:0] data);
    logic       tick, wr, rd;
    logic [7:0] off;
    tick = ((m_cyc % DIV) == DIV - 1);
    m_cyc++;
    off = addr - BASE;
    wr  = we && (off < 8'd4);
    rd  = re && !we && (off < 8'd4);
    exp_oe   = rd;
    exp_dout = rd ? model_read(off[1:0]) : 8'h00;
    if (rd && off == 8'd2) begin
      m_tflag = 1'b0;
      m_err   = 1'b0;
    end
    if (wr && off == 8'd0) begin
      m_cmd   = data[3:0];
      m_timer = m_tmo;
    end else if (m_cmd != 4'd0 && tick && m_tmo != 8'd0) begin
      if (m_timer <= 8'd1) begin
        m_cmd   = 4'd0;
        m_timer = 8'd0;
        m_tflag = 1'b1;
      end else begin
        m_timer = m_timer - 8'd1;
      end
    end
    if (wr && off == 8'd1) begin
      if ($countones(data[3:0]) == 1) m_colour = data[3:0];
      else                            m_err    = 1'b1;
    end
    if (wr && off == 8'd3) m_tmo = data;
  endtask

  // Drive one bus cycle from a falling edge; returns at the next falling edge.
  task automatic bus_cycle(input logic we, input logic re, input logic [7:0] addr,
                           input logic [7:0] data);
    BUS_WE      = we;
    BUS_RE      = re;
    BUS_ADDR    = addr;
    BUS_DATA_IN = data;
    @(posedge CLK);
    model_step(we, re, addr, data);
    @(negedge CLK);
    BUS_WE = 1'b0;
    BUS_RE = 1'b0;
  endtask

  function automatic logic [17:0] observed();
    return {COMMAND, COLOUR_SEL, CMD_ACTIVE, BUS_DATA_OE, (BUS_DATA_OE ? BUS_DATA_OUT : 8'h00)};
  endfunction

  function automatic logic [17:0] expected();
    return {m_cmd, m_colour, (m_cmd != 4'd0), exp_oe, exp_dout};
  endfunction

  task automatic test_reset();
    RST = 1'b1; BUS_WE = 1'b0; BUS_RE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({COMMAND, COLOUR_SEL, CMD_ACTIVE, BUS_DATA_OE, BUS_DATA_OUT} !== {4'h0, 4'h1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_values: got %h %h %b %b %h required 0 1 0 0 00",
               COMMAND, COLOUR_SEL, CMD_ACTIVE, BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
    RST = 1'b0;
    model_reset();
    bus_cycle(1'b0, 1'b1, BASE + 8'd1, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h01})
      $display("FAIL reset_read_colour: got oe=%b data=%h required oe=1 data=01", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
    bus_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    n_checks++;
    if (BUS_DATA_OE !== 1'b0)
      $display("FAIL oe_one_cycle: got oe=%b required 0", BUS_DATA_OE);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE + 8'd3, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT, COMMAND} !== {1'b1, 8'd50, 4'h0})
      $display("FAIL reset_read_timeout: got oe=%b data=%0d cmd=%h required oe=1 data=50 cmd=0",
               BUS_DATA_OE, BUS_DATA_OUT, COMMAND);
    else n_pass++;
  endtask

  task automatic test_cmd_write();
    bus_cycle(1'b1, 1'b0, BASE, 8'hF5);
    n_checks++;
    if ({COMMAND, CMD_ACTIVE} !== {4'h5, 1'b1})
      $display("FAIL cmd_write: got cmd=%h active=%b required cmd=5 active=1", COMMAND, CMD_ACTIVE);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h05})
      $display("FAIL cmd_readback: got oe=%b data=%h required oe=1 data=05", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    bit expired = 1'b0;
    bus_cycle(1'b1, 1'b0, BASE + 8'd3, 8'd2);
    bus_cycle(1'b1, 1'b0, BASE, 8'h08);
    n_checks++;
    if (COMMAND !== 4'h8)
      $display("FAIL watchdog_load: got cmd=%h required 8", COMMAND);
    else n_pass++;
    for (int i = 0; i < 4 * DIV && !expired; i++) begin
      bus_cycle(1'b0, 1'b0, 8'h00, 8'h00);
      if (COMMAND === 4'h0) expired = 1'b1;
    end
    n_checks++;
    if (!expired || observed() !== expected())
      $display("FAIL watchdog_expiry: got expired=%b state=%h required expired=1 state=%h",
               expired, observed(), expected());
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h02})
      $display("FAIL status_timeout: got oe=%b data=%h required oe=1 data=02", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h00})
      $display("FAIL status_cleared: got oe=%b data=%h required oe=1 data=00", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
  endtask

  task automatic test_colour();
    bus_cycle(1'b1, 1'b0, BASE + 8'd1, 8'h03);
    n_checks++;
    if (COLOUR_SEL !== 4'b0001)
      $display("FAIL colour_bad_ignored: got %b required 0001", COLOUR_SEL);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h04})
      $display("FAIL status_err: got oe=%b data=%h required oe=1 data=04", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
    bus_cycle(1'b1, 1'b0, BASE + 8'd1, 8'h04);
    n_checks++;
    if (COLOUR_SEL !== 4'b0100)
      $display("FAIL colour_good: got %b required 0100", COLOUR_SEL);
    else n_pass++;
  endtask

  task automatic test_out_of_window();
    bus_cycle(1'b1, 1'b0, 8'h40, 8'h04);
    n_checks++;
    if (observed() !== expected() || BUS_DATA_OE !== 1'b0)
      $display("FAIL outside_write: got %h required %h", observed(), expected());
    else n_pass++;
    bus_cycle(1'b0, 1'b1, 8'h40, 8'h00);
    n_checks++;
    if (BUS_DATA_OE !== 1'b0 || observed() !== expected())
      $display("FAIL outside_read: got oe=%b state=%h required oe=0 state=%h",
               BUS_DATA_OE, observed(), expected());
    else n_pass++;
  endtask

  task automatic test_write_on_expiry();
    int budget = 0;
    bus_cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
    bus_cycle(1'b1, 1'b0, BASE + 8'd3, 8'd1);
    bus_cycle(1'b1, 1'b0, BASE, 8'h02);
    while ((m_cyc % DIV) != DIV - 1 && budget < 2 * DIV) begin
      bus_cycle(1'b0, 1'b0, 8'h00, 8'h00);
      budget++;
    end
    bus_cycle(1'b1, 1'b0, BASE, 8'h03);
    n_checks++;
    if ({COMMAND, CMD_ACTIVE} !== {4'h3, 1'b1})
      $display("FAIL write_on_expiry_cmd: got cmd=%h active=%b required cmd=3 active=1", COMMAND, CMD_ACTIVE);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'h01})
      $display("FAIL write_on_expiry_flag: got oe=%b data=%h required oe=1 data=01", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       we, re;
    logic [7:0] addr, data;
    int         errs = 0;
    for (int i = 0; i < 400; i++) begin
      we = 1'b0; re = 1'b0;
      addr = BASE + 8'($urandom_range(0, 3));
      data = 8'($urandom);
      case ($urandom_range(0, 9))
        5: begin we = 1'b1; addr = BASE; end
        6: begin we = 1'b1; addr = BASE + 8'd1; end
        7: begin we = 1'b1; addr = BASE + 8'd3; data = 8'($urandom_range(0, 3)); end
        8: re = 1'b1;
        9: begin we = 1'($urandom); re = 1'b1;
             if ($urandom_range(0, 1) == 1) addr = 8'($urandom_range(0, 1)) ? 8'h8F : 8'h94;
           end
        default: ;
      endcase
      bus_cycle(we, re, addr, data);
      n_checks++;
      if (observed() !== expected()) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %h required %h", i, observed(), expected());
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bus_cycle(1'b1, 1'b0, BASE + 8'd3, 8'h20);
    bus_cycle(1'b1, 1'b0, BASE + 8'd1, 8'h08);
    bus_cycle(1'b1, 1'b0, BASE, 8'h09);
    n_checks++;
    if ({COMMAND, CMD_ACTIVE} !== {4'h9, 1'b1})
      $display("FAIL pre_reset_active: got cmd=%h active=%b required cmd=9 active=1", COMMAND, CMD_ACTIVE);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({COMMAND, CMD_ACTIVE, COLOUR_SEL, BUS_DATA_OE} !== {4'h0, 1'b0, 4'b0001, 1'b0})
      $display("FAIL async_reset: got cmd=%h active=%b colour=%b oe=%b required 0 0 0001 0",
               COMMAND, CMD_ACTIVE, COLOUR_SEL, BUS_DATA_OE);
    else n_pass++;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    bus_cycle(1'b0, 1'b1, BASE + 8'd3, 8'h00);
    n_checks++;
    if ({BUS_DATA_OE, BUS_DATA_OUT} !== {1'b1, 8'd50})
      $display("FAIL reset_timeout_reg: got oe=%b data=%0d required oe=1 data=50", BUS_DATA_OE, BUS_DATA_OUT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_watchdog();
    test_colour();
    test_out_of_window();
    test_write_on_expiry();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
